// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program-counter generator.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_BOOT,
        PC_RUN,
        PC_HALTED
    } pc_state_t;

    // Only the two low PC bits can carry an alignment fault.
    function automatic logic pc_misaligned(input logic [1:0] pc_low, input int ialign);
        if (ialign == 16) begin
            return pc_low[0];
        end
        return |pc_low;
    endfunction

endpackage

// File: rtl/pc_generator.sv
// Program-counter generator: valid/ready fetch handshake, epoch-tagged trap and
// branch redirects, and a boot/run/halt state machine.
module pc_generator
    import pc_pkg::*;
#(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0040_0000),
    parameter int IALIGN = 32,
    parameter int EPOCH_W = 2
) (
    input  logic               clock,
    input  logic               reset,
    output logic               fetch_valid,
    input  logic               fetch_ready,
    output logic [XLEN-1:0]    fetch_pc,
    output logic [EPOCH_W-1:0] fetch_epoch,
    output logic               fetch_misaligned,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    input  logic               trap_valid,
    input  logic [XLEN-1:0]    trap_pc,
    input  logic               halt_req,
    output logic               halted
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(IALIGN / 8);

    pc_state_t          state_reg, state_next;
    logic [XLEN-1:0]    pc_reg, pc_next;
    logic [EPOCH_W-1:0] epoch_reg, epoch_next;
    logic               transfer;
    logic               redirect_applied;

    assign transfer         = (state_reg == PC_RUN) && fetch_ready;
    assign redirect_applied = trap_valid || redirect_valid;

    // Trap beats branch; a redirect taken together with a transfer still wins,
    // and the bumped epoch marks the just-accepted word as stale.
    always_comb begin
        pc_next    = pc_reg;
        epoch_next = epoch_reg;
        if (trap_valid) begin
            pc_next    = trap_pc;
            epoch_next = epoch_reg + EPOCH_W'(1);
        end else if (redirect_valid) begin
            pc_next    = redirect_pc;
            epoch_next = epoch_reg + EPOCH_W'(1);
        end else if (transfer) begin
            pc_next    = pc_reg + PC_STEP;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            PC_BOOT: begin
                state_next = PC_RUN;
            end
            PC_RUN: begin
                // Only leave RUN on a cycle where valid may legally drop.
                if (halt_req && (transfer || redirect_applied)) begin
                    state_next = PC_HALTED;
                end
            end
            PC_HALTED: begin
                if (!halt_req) begin
                    state_next = PC_RUN;
                end
            end
            default: begin
                state_next = PC_BOOT;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= PC_BOOT;
            pc_reg    <= RESET_VECTOR;
            epoch_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            epoch_reg <= epoch_next;
        end
    end

    assign fetch_valid      = (state_reg == PC_RUN);
    assign halted           = (state_reg == PC_HALTED);
    assign fetch_pc         = pc_reg;
    assign fetch_epoch      = epoch_reg;
    assign fetch_misaligned = pc_misaligned(pc_reg[1:0], IALIGN);

endmodule

// File: tb/tb_pc_generator.sv
// Directed scoreboard bench for pc_generator; a 32-bit-aligned and a 16-bit-aligned
// instance share one stimulus stream.
module tb_pc_generator;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic        halt_req;

    logic        valid_a, mis_a, halted_a;
    logic [31:0] pc_a;
    logic [1:0]  epoch_a;
    logic        valid_b, mis_b, halted_b;
    logic [31:0] pc_b;
    logic [1:0]  epoch_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic        valid;
        logic [31:0] pc;
        logic [1:0]  epoch;
        logic        mis;
        logic        hlt;
        logic [31:0] pc_b;
        logic        mis_b;
    } exp_t;

    exp_t sb[$];

    always #5 clock = ~clock;

    pc_generator #(.XLEN(32), .RESET_VECTOR(32'h0040_0000), .IALIGN(32), .EPOCH_W(2)) dut_a (
        .clock            (clock),
        .reset            (reset),
        .fetch_valid      (valid_a),
        .fetch_ready      (fetch_ready),
        .fetch_pc         (pc_a),
        .fetch_epoch      (epoch_a),
        .fetch_misaligned (mis_a),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .trap_valid       (trap_valid),
        .trap_pc          (trap_pc),
        .halt_req         (halt_req),
        .halted           (halted_a)
    );

    pc_generator #(.XLEN(32), .RESET_VECTOR(32'h0040_0000), .IALIGN(16), .EPOCH_W(2)) dut_b (
        .clock            (clock),
        .reset            (reset),
        .fetch_valid      (valid_b),
        .fetch_ready      (fetch_ready),
        .fetch_pc         (pc_b),
        .fetch_epoch      (epoch_b),
        .fetch_misaligned (mis_b),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .trap_valid       (trap_valid),
        .trap_pc          (trap_pc),
        .halt_req         (halt_req),
        .halted           (halted_b)
    );

    task automatic cmp(input string tag, input string field, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, expv);
        end
    endtask

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        $display("step %-12s pc_a=%h pc_b=%h epoch=%0d valid=%0b halted=%0b",
                 e.tag, pc_a, pc_b, epoch_a, valid_a, halted_a);
        cmp(e.tag, "valid_a",  32'(valid_a),  32'(e.valid));
        cmp(e.tag, "pc_a",     pc_a,          e.pc);
        cmp(e.tag, "epoch_a",  32'(epoch_a),  32'(e.epoch));
        cmp(e.tag, "mis_a",    32'(mis_a),    32'(e.mis));
        cmp(e.tag, "halted_a", 32'(halted_a), 32'(e.hlt));
        cmp(e.tag, "valid_b",  32'(valid_b),  32'(e.valid));
        cmp(e.tag, "pc_b",     pc_b,          e.pc_b);
        cmp(e.tag, "epoch_b",  32'(epoch_b),  32'(e.epoch));
        cmp(e.tag, "mis_b",    32'(mis_b),    32'(e.mis_b));
        cmp(e.tag, "halted_b", 32'(halted_b), 32'(e.hlt));
    endtask

    task automatic expect_now(input string tag, input logic v, input logic [31:0] pc, input logic [1:0] ep,
                              input logic mis, input logic hlt, input logic [31:0] pcb, input logic misb);
        sb.push_back('{tag, v, pc, ep, mis, hlt, pcb, misb});
        check_out();
    endtask

    // Expected state after the next rising edge, sampled 1 time unit later.
    task automatic step(input string tag, input logic v, input logic [31:0] pc, input logic [1:0] ep,
                        input logic mis, input logic hlt, input logic [31:0] pcb, input logic misb);
        sb.push_back('{tag, v, pc, ep, mis, hlt, pcb, misb});
        @(posedge clock);
        #1;
        check_out();
    endtask

    initial begin
        reset          = 1'b1;
        fetch_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        trap_valid     = 1'b0;
        trap_pc        = 32'h0;
        halt_req       = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        expect_now("reset", 0, 32'h0040_0000, 0, 0, 0, 32'h0040_0000, 0);
        reset = 1'b0;

        step("boot_exit", 1, 32'h0040_0000, 0, 0, 0, 32'h0040_0000, 0);
        step("seq1",      1, 32'h0040_0004, 0, 0, 0, 32'h0040_0002, 0);
        step("seq2",      1, 32'h0040_0008, 0, 0, 0, 32'h0040_0004, 0);

        fetch_ready = 1'b0;
        step("bp1",       1, 32'h0040_0008, 0, 0, 0, 32'h0040_0004, 0);
        step("bp2",       1, 32'h0040_0008, 0, 0, 0, 32'h0040_0004, 0);
        step("bp3",       1, 32'h0040_0008, 0, 0, 0, 32'h0040_0004, 0);
        fetch_ready = 1'b1;
        step("bp_release", 1, 32'h0040_000C, 0, 0, 0, 32'h0040_0006, 0);

        trap_valid = 1'b1; trap_pc = 32'h80;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step("trap_prio", 1, 32'h80, 1, 0, 0, 32'h80, 0);
        trap_valid = 1'b0;

        fetch_ready = 1'b0;
        redirect_pc = 32'h100;
        step("redir_e2",  1, 32'h100, 2, 0, 0, 32'h100, 0);
        redirect_pc = 32'h104;
        step("redir_e3",  1, 32'h104, 3, 0, 0, 32'h104, 0);
        redirect_pc = 32'h108;
        step("redir_e0",  1, 32'h108, 0, 0, 0, 32'h108, 0);
        redirect_pc = 32'h10C;
        step("redir_e1",  1, 32'h10C, 1, 0, 0, 32'h10C, 0);
        redirect_pc = 32'h102;
        step("misalign",  1, 32'h102, 2, 1, 0, 32'h102, 0);
        redirect_valid = 1'b0;
        fetch_ready = 1'b1;
        step("mis_adv",   1, 32'h106, 2, 1, 0, 32'h104, 0);

        fetch_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step("realign",   1, 32'h200, 3, 0, 0, 32'h200, 0);
        redirect_valid = 1'b0;

        halt_req = 1'b1;
        step("halt_wait1", 1, 32'h200, 3, 0, 0, 32'h200, 0);
        step("halt_wait2", 1, 32'h200, 3, 0, 0, 32'h200, 0);
        fetch_ready = 1'b1;
        step("halt_enter", 0, 32'h204, 3, 0, 1, 32'h202, 0);
        step("halt_hold",  0, 32'h204, 3, 0, 1, 32'h202, 0);
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        step("halt_redir", 0, 32'h300, 0, 0, 1, 32'h300, 0);
        redirect_valid = 1'b0;
        halt_req = 1'b0;
        step("resume",     1, 32'h300, 0, 0, 0, 32'h300, 0);
        step("resume_seq", 1, 32'h304, 0, 0, 0, 32'h302, 0);

        #2;
        reset = 1'b1;
        #1;
        expect_now("async_rst", 0, 32'h0040_0000, 0, 0, 0, 32'h0040_0000, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        step("reboot",     1, 32'h0040_0000, 0, 0, 0, 32'h0040_0000, 0);
        step("reboot_seq", 1, 32'h0040_0004, 0, 0, 0, 32'h0040_0002, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
